gb_window_lp: RTL and testbench

GB_WINDOW_LP -- requirements
Module: gb_window_lp

---
 rtl/gb_window_lp.sv | 114 +++++++++++
 tb/tb_gb_window_lp.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gb_window_lp.sv
// Ingress FIFO feeding a 3-tap sliding window with stride-1/2 decimation and
// optional zero left pad; windows are presented one cycle after the pop that completes them.
module gb_window_lp #(
  parameter int WORD_BITS  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          En_in,
  input  logic                          layer_done_in,
  input  logic                          Stride_in,
  input  logic                          Padding_in,
  input  logic                          Pixel_0_valid_in,
  input  logic signed [WORD_BITS-1:0]   Pixel_0_in,
  input  logic                          Pixel_1_valid_in,
  input  logic signed [WORD_BITS-1:0]   Pixel_1_in,
  output logic signed [WORD_BITS-1:0]   Pixel_0_out,
  output logic signed [WORD_BITS-1:0]   Pixel_1_out,
  output logic signed [WORD_BITS-1:0]   Pixel_2_out,
  output logic                          Pixel_0_valid_out,
  output logic                          Pixel_1_valid_out,
  output logic                          Pixel_2_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_count_out,
  output logic                          Overflow_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [1:0] sat_fill(input logic [1:0] f);
    return (f == 2'd3) ? 2'd3 : f + 2'd1;
  endfunction

  logic signed [WORD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_addr;
  logic [CW-1:0] count_q, count_d, free_w;
  logic signed [WORD_BITS-1:0] t0_q, t1_q, t2_q, t0_d, t1_d, t2_d;
  logic signed [WORD_BITS-1:0] o0_q, o1_q, o2_q, o0_d, o1_d, o2_d;
  logic [1:0] fill_q, fill_d;
  logic phase_q, phase_d, pend_q, pend_d, vld_q, vld_d, ovf_q, ovf_d;
  logic wr0_en, wr1_en, drop, pop, full_evt, mem_we0, mem_we1;

  // Capacity is judged on start-of-cycle occupancy; a pop does not make room.
  always_comb begin
    free_w   = CW'(FIFO_DEPTH) - count_q;
    wr0_en   = Pixel_0_valid_in && (free_w != '0);
    wr1_en   = Pixel_1_valid_in && (free_w > (wr0_en ? CW'(1) : CW'(0)));
    drop     = (Pixel_0_valid_in && !wr0_en) || (Pixel_1_valid_in && !wr1_en);
    pop      = En_in && (count_q != '0);
    full_evt = pop && (sat_fill(fill_q) == 2'd3);
    wr1_addr = wr_ptr_q + AW'(wr0_en);
    mem_we0  = wr0_en && !RST && !layer_done_in;
    mem_we1  = wr1_en && !RST && !layer_done_in;

    wr_ptr_d = wr_ptr_q;  rd_ptr_d = rd_ptr_q;  count_d = count_q;
    t0_d = t0_q;  t1_d = t1_q;  t2_d = t2_q;
    o0_d = o0_q;  o1_d = o1_q;  o2_d = o2_q;
    fill_d = fill_q;  phase_d = phase_q;  pend_d = 1'b0;
    vld_d = 1'b0;  ovf_d = ovf_q;

    if (RST) begin
      wr_ptr_d = '0;  rd_ptr_d = '0;  count_d = '0;
      t0_d = '0;  t1_d = '0;  t2_d = '0;
      o0_d = '0;  o1_d = '0;  o2_d = '0;
      fill_d = 2'd0;  phase_d = 1'b0;  ovf_d = 1'b0;
    end else if (layer_done_in) begin
      // Layer boundary: everything in flight is discarded, output data is left as-is.
      wr_ptr_d = '0;  rd_ptr_d = '0;  count_d = '0;
      t0_d = '0;  t1_d = '0;  t2_d = '0;
      fill_d = {1'b0, Padding_in};  phase_d = 1'b0;  ovf_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(wr0_en) + AW'(wr1_en);
      count_d  = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
      ovf_d    = ovf_q | drop;
      if (pend_q) begin
        o0_d = t0_q;  o1_d = t1_q;  o2_d = t2_q;
        vld_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        t0_d = t1_q;  t1_d = t2_q;  t2_d = mem_q[rd_ptr_q];
        fill_d = sat_fill(fill_q);
      end
      // Stride 2 keeps every other full window, starting with the first.
      if (full_evt) begin
        pend_d  = !Stride_in || !phase_q;
        phase_d = phase_q ^ Stride_in;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we0) mem_q[wr_ptr_q] <= Pixel_0_in;
    if (mem_we1) mem_q[wr1_addr] <= Pixel_1_in;
  end

  always_ff @(posedge CLK) begin
    wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  count_q <= count_d;
    t0_q <= t0_d;  t1_q <= t1_d;  t2_q <= t2_d;
    o0_q <= o0_d;  o1_q <= o1_d;  o2_q <= o2_d;
    fill_q <= fill_d;  phase_q <= phase_d;  pend_q <= pend_d;
    vld_q <= vld_d;  ovf_q <= ovf_d;
  end

  assign Pixel_0_out       = o0_q;
  assign Pixel_1_out       = o1_q;
  assign Pixel_2_out       = o2_q;
  assign Pixel_0_valid_out = vld_q;
  assign Pixel_1_valid_out = vld_q;
  assign Pixel_2_valid_out = vld_q;
  assign Fifo_count_out    = count_q;
  assign Overflow_out      = ovf_q;

endmodule

// File: tb/tb_gb_window_lp.sv
// Randomized and directed bench for gb_window_lp against a queue-based window model.
module tb_gb_window_lp;
  localparam int WB = 16;
  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic RST, En_in, layer_done_in, Stride_in, Padding_in;
  logic v0, v1;
  logic signed [WB-1:0] p0, p1;
  logic signed [WB-1:0] o0, o1, o2;
  logic ov0, ov1, ov2, ovf;
  logic [$clog2(DEPTH):0] cnt;

  gb_window_lp #(.WORD_BITS(WB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .En_in(En_in), .layer_done_in(layer_done_in),
    .Stride_in(Stride_in), .Padding_in(Padding_in),
    .Pixel_0_valid_in(v0), .Pixel_0_in(p0),
    .Pixel_1_valid_in(v1), .Pixel_1_in(p1),
    .Pixel_0_out(o0), .Pixel_1_out(o1), .Pixel_2_out(o2),
    .Pixel_0_valid_out(ov0), .Pixel_1_valid_out(ov1), .Pixel_2_valid_out(ov2),
    .Fifo_count_out(cnt), .Overflow_out(ovf)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: the FIFO is a queue, the window is the last three popped pixels.
  int fifo[$];
  int tap[3], pend_w[3], exp_out[3];
  int fill, phase;
  bit pend, exp_vld, exp_ovf;
  int obs[$];

  task automatic model_step();
    int occ, space, x;
    if (RST) begin
      fifo.delete(); tap = '{0, 0, 0}; exp_out = '{0, 0, 0};
      fill = 0; phase = 0; pend = 0; exp_vld = 0; exp_ovf = 0;
      return;
    end
    if (layer_done_in) begin
      fifo.delete(); tap = '{0, 0, 0};
      fill = int'(Padding_in); phase = 0; pend = 0; exp_vld = 0; exp_ovf = 0;
      return;
    end
    exp_vld = pend;
    if (pend) exp_out = pend_w;
    pend = 0;
    occ = fifo.size();
    if (En_in && occ > 0) begin
      x = fifo.pop_front();
      tap = '{tap[1], tap[2], x};
      if (fill < 3) fill++;
      if (fill == 3) begin
        if (!Stride_in || phase == 0) begin pend = 1; pend_w = tap; end
        if (Stride_in) phase ^= 1;
      end
    end
    space = DEPTH - occ;
    if (v0) begin if (space > 0) begin fifo.push_back(int'(p0)); space--; end else exp_ovf = 1; end
    if (v1) begin if (space > 0) begin fifo.push_back(int'(p1)); space--; end else exp_ovf = 1; end
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    check("count", int'(cnt), fifo.size());
    check("ovf", int'(ovf), int'(exp_ovf));
    check("vld0", int'(ov0), int'(exp_vld));
    check("vld1", int'(ov1), int'(exp_vld));
    check("vld2", int'(ov2), int'(exp_vld));
    check("out0", int'(o0), exp_out[0]);
    check("out1", int'(o1), exp_out[1]);
    check("out2", int'(o2), exp_out[2]);
    if (ov0) begin obs.push_back(int'(o0)); obs.push_back(int'(o1)); obs.push_back(int'(o2)); end
  endtask

  task automatic cyc(input bit a, input int pa, input bit b, input int pb);
    v0 = a; p0 = WB'(pa); v1 = b; p1 = WB'(pb);
    step();
    v0 = 0; v1 = 0;
  endtask

  task automatic new_layer(input bit stride, input bit pad);
    Stride_in = stride; Padding_in = pad; layer_done_in = 1;
    cyc(0, 0, 0, 0);
    layer_done_in = 0;
    obs.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic cmp_win(input string tag, input int exp[$]);
    check({tag, "_len"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      check($sformatf("%s_%0d", tag, i), obs[i], exp[i]);
  endtask

  initial begin
    int e[$];
    RST = 1; En_in = 1; layer_done_in = 0; Stride_in = 0; Padding_in = 0;
    v0 = 0; v1 = 0; p0 = '0; p1 = '0;
    idle(2);
    check("rst_cnt", int'(cnt), 0);
    check("rst_vld", int'(ov0), 0);
    RST = 0;

    new_layer(0, 0);
    for (int k = 1; k <= 4; k++) cyc(1, k, 0, 0);
    idle(4);
    e = '{1, 2, 3, 2, 3, 4}; cmp_win("s1", e);

    new_layer(1, 0);
    for (int k = 1; k <= 7; k++) cyc(1, k, 0, 0);
    idle(6);
    e = '{1, 2, 3, 3, 4, 5, 5, 6, 7}; cmp_win("s2", e);

    new_layer(0, 1);
    cyc(1, 5, 0, 0); cyc(1, 6, 0, 0);
    idle(4);
    e = '{0, 5, 6}; cmp_win("pad", e);

    new_layer(0, 0);
    En_in = 0;
    for (int k = 0; k < 5; k++) cyc(1, 2 * k + 1, 1, 2 * k + 2);
    check("full_cnt", int'(cnt), 8);
    check("full_ovf", int'(ovf), 1);
    En_in = 1;
    idle(12);
    e = '{1, 2, 3, 2, 3, 4, 3, 4, 5, 4, 5, 6, 5, 6, 7, 6, 7, 8}; cmp_win("drain", e);

    new_layer(0, 0);
    En_in = 0;
    for (int k = 0; k < 4; k++) cyc(1, 10 + k, 1, 20 + k);
    check("pre_ovf", int'(ovf), 0);
    En_in = 1;
    cyc(1, 99, 0, 0);
    check("wp_cnt", int'(cnt), 7);
    check("wp_ovf", int'(ovf), 1);
    idle(3);

    Padding_in = 0; layer_done_in = 1;
    cyc(1, 9, 0, 0);
    layer_done_in = 0;
    obs.delete();
    check("ld_cnt", int'(cnt), 0);
    idle(5);
    check("ld_nowin", obs.size(), 0);
    check("ld_ovf", int'(ovf), 0);

    cyc(1, 3, 1, 4); cyc(1, 5, 0, 0);
    RST = 1; cyc(1, 7, 0, 0); RST = 0;
    check("mid_rst_cnt", int'(cnt), 0);
    idle(1);
    check("mid_rst_vld", int'(ov0), 0);

    for (int i = 0; i < 3000; i++) begin
      En_in = ($urandom_range(0, 3) != 0);
      RST = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) begin
        layer_done_in = 1;
        Stride_in = $urandom_range(0, 1);
        Padding_in = $urandom_range(0, 1);
      end
      cyc($urandom_range(0, 1), int'($urandom), $urandom_range(0, 1), int'($urandom));
      RST = 0; layer_done_in = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
